// File: rtl/ahb_pkg.sv
// Shared AHB definitions: transfer types, HSIZE codes, local response codes
// and the command legality rule used by every master port.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic [1:0] RSP_OKAY    = 2'd0;
    localparam logic [1:0] RSP_BUS_ERR = 2'd1;
    localparam logic [1:0] RSP_TIMEOUT = 2'd2;
    localparam logic [1:0] RSP_ILLEGAL = 2'd3;

    // A command is legal when its size fits the bus and the address is size-aligned.
    function automatic logic cmd_legal(input logic [2:0] size,
                                       input logic [2:0] addr_lsb,
                                       input logic       wide_bus);
        logic ok;
        case (size)
            HSIZE_BYTE:  ok = 1'b1;
            HSIZE_HALF:  ok = (addr_lsb[0] == 1'b0);
            HSIZE_WORD:  ok = (addr_lsb[1:0] == 2'b00);
            HSIZE_DWORD: ok = wide_bus && (addr_lsb == 3'b000);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ahb_master_port.sv
// Single-transfer AHB master: turns one local command into a request/grant,
// NONSEQ address phase and data phase, then returns a one-cycle response.
module ahb_master_port
    import ahb_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int GRANT_TIMEOUT = 255
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_size,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic              hreq,
    input  logic              hgrant,
    input  logic              hready,
    input  logic              hresp,
    input  logic [DATA_W-1:0] hrdata,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [DATA_W-1:0] hwdata
);

    localparam int               CNT_W     = $clog2(GRANT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(GRANT_TIMEOUT);
    localparam logic             WIDE_BUS  = (DATA_W == 64);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] tmo_nxt;
    logic             cmd_ok;

    assign cmd_ok    = cmd_legal(cmd_size, cmd_addr[2:0], WIDE_BUS);
    assign tmo_nxt   = tmo_cnt + 1'b1;
    assign cmd_ready = (state == S_IDLE);
    // NONSEQ is only driven while the arbiter is actually granting us.
    assign htrans    = (state == S_REQ && hgrant) ? HTRANS_NONSEQ : HTRANS_IDLE;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= S_IDLE;
            tmo_cnt   <= '0;
            hreq      <= 1'b0;
            haddr     <= '0;
            hwrite    <= 1'b0;
            hsize     <= '0;
            hwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= RSP_OKAY;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_ok) begin
                            // Bus-side registers double as the command copy, so they
                            // keep their last values when an illegal command is rejected.
                            haddr   <= cmd_addr;
                            hwrite  <= cmd_write;
                            hsize   <= cmd_size;
                            hwdata  <= cmd_wdata;
                            tmo_cnt <= '0;
                            hreq    <= 1'b1;
                            state   <= S_REQ;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= RSP_ILLEGAL;
                            rsp_rdata <= '0;
                            state     <= S_RESP;
                        end
                    end
                end
                S_REQ: begin
                    if (hgrant && hready) begin
                        hreq  <= 1'b0;
                        state <= S_DATA;
                    end else if (tmo_nxt == TMO_LIMIT) begin
                        tmo_cnt   <= tmo_nxt;
                        hreq      <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= RSP_TIMEOUT;
                        rsp_rdata <= '0;
                        state     <= S_RESP;
                    end else begin
                        tmo_cnt <= tmo_nxt;
                    end
                end
                S_DATA: begin
                    // hgrant is deliberately not looked at here.
                    if (hready) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= hresp ? RSP_BUS_ERR : RSP_OKAY;
                        rsp_rdata <= hwrite ? '0 : hrdata;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_master_port.sv
// Randomized bench for ahb_master_port: a bus responder plays arbiter and slave
// from a per-command plan, and a scoreboard checks every response pulse.
module tb_ahb_master_port;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TMO    = 8;

    logic              hclk = 1'b0;
    logic              hresetn = 1'b0;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [2:0]        cmd_size;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_err;
    logic              hreq, hgrant, hready, hresp;
    logic [DATA_W-1:0] hrdata;
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [DATA_W-1:0] hwdata;

    ahb_master_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .GRANT_TIMEOUT(TMO)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .hreq(hreq), .hgrant(hgrant), .hready(hready), .hresp(hresp), .hrdata(hrdata),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata)
    );

    always #5 hclk = ~hclk;

    int cyc = 0;
    always @(posedge hclk) cyc <= cyc + 1;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        int          g;      // REQ cycles without grant before the grant
        int          w;      // data-phase wait states
        bit          err;    // slave answers with a two-cycle ERROR
        logic [31:0] rdata;
    } plan_t;

    typedef struct {
        logic [1:0]  err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    plan_t plan_q[$];
    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    phase  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit legal(input plan_t p);
        int align;
        align = 1 << p.size;
        return (p.size <= ((DATA_W == 64) ? 3 : 2)) && ((p.addr % align) == 0);
    endfunction

    // Expected response from the command and the bus behaviour planned for it.
    function automatic exp_t predict(input plan_t p, input int acc);
        exp_t e;
        if (!legal(p)) begin
            e.err = 2'd3; e.rdata = 32'h0; e.cyc = acc + 1;
        end else if (p.g >= TMO) begin
            e.err = 2'd2; e.rdata = 32'h0; e.cyc = acc + TMO + 1;
        end else begin
            e.err   = p.err ? 2'd1 : 2'd0;
            e.rdata = p.write ? 32'h0 : p.rdata;
            e.cyc   = acc + (p.g + 1) + (p.w + 1) + 1;
        end
        return e;
    endfunction

    function automatic plan_t mk(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                                 input logic [31:0] wd, input int g, input int w,
                                 input bit er, input logic [31:0] rd);
        plan_t p;
        p.write = wr; p.addr = a; p.size = sz; p.wdata = wd;
        p.g = g; p.w = w; p.err = er; p.rdata = rd;
        return p;
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input plan_t p, input bit expect_rsp);
        int waitc = 0;
        cmd_valid = 1'b1; cmd_write = p.write; cmd_addr = p.addr;
        cmd_size = p.size; cmd_wdata = p.wdata;
        while (!cmd_ready) begin
            @(negedge hclk);
            waitc++;
            if (waitc > 200) begin
                checks++; errors++;
                $display("FAIL cmd_accept: got no cmd_ready expected cmd_ready within 200 cycles");
                cmd_valid = 1'b0;
                return;
            end
        end
        if (legal(p)) plan_q.push_back(p);
        if (expect_rsp) exp_q.push_back(predict(p, cyc));
        @(negedge hclk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge hclk);
            n++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_hreq"}, 64'(hreq), 64'd0);
        chk({tag, "_htrans"}, 64'(htrans), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
        chk({tag, "_haddr"}, 64'(haddr), 64'd0);
        chk({tag, "_hwrite"}, 64'(hwrite), 64'd0);
        chk({tag, "_hsize"}, 64'(hsize), 64'd0);
        chk({tag, "_hwdata"}, 64'(hwdata), 64'd0);
        chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    endtask

    // Bus responder: arbiter and slave driven from the plan of the current command.
    initial begin
        plan_t cur;
        int rc = 0;
        int dc = 0;
        hgrant = 1'b0; hready = 1'b1; hresp = 1'b0; hrdata = '0;
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0);
        forever begin
            @(negedge hclk);
            if (!hresetn) begin
                phase = 0; hgrant = 1'b0; hready = 1'b1; hresp = 1'b0;
                continue;
            end
            if (phase == 0 && hreq) begin
                if (plan_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_hreq: got hreq=1 expected no request (cycle %0d)", cyc);
                    cur = mk(0, haddr, hsize, 0, 0, 0, 0, 0);
                end else begin
                    cur = plan_q.pop_front();
                end
                rc = 0;
                phase = 1;
            end
            if (phase == 1) begin
                if (!hreq) begin
                    chk("timeout_req_cycles", 64'(rc), 64'(TMO));
                    hgrant = 1'b0;
                    phase = 0;
                end else if (rc == cur.g) begin
                    hgrant = 1'b1; hready = 1'b1; hresp = 1'b0;
                    #1;
                    chk("addr_htrans_nonseq", 64'(htrans), 64'd2);
                    chk("addr_haddr", 64'(haddr), 64'(cur.addr));
                    chk("addr_hwrite", 64'(hwrite), 64'(cur.write));
                    chk("addr_hsize", 64'(hsize), 64'(cur.size));
                    dc = 0;
                    phase = 2;
                end else begin
                    hgrant = 1'b0; hready = 1'($urandom); hresp = 1'b0;
                    #1;
                    chk("req_htrans_idle", 64'(htrans), 64'd0);
                    chk("req_haddr", 64'(haddr), 64'(cur.addr));
                    rc++;
                end
            end else if (phase == 2) begin
                hgrant = 1'($urandom);
                hready = (dc == cur.w);
                hresp  = cur.err && (dc >= cur.w - 1);
                hrdata = (dc == cur.w) ? cur.rdata : $urandom;
                #1;
                chk("data_hreq", 64'(hreq), 64'd0);
                chk("data_htrans", 64'(htrans), 64'd0);
                chk("data_haddr_hold", 64'(haddr), 64'(cur.addr));
                if (cur.write) chk("data_hwdata", 64'(hwdata), 64'(cur.wdata));
                if (dc == cur.w) phase = 0;
                dc++;
            end else begin
                hgrant = 1'($urandom); hready = 1'($urandom); hresp = 1'b0;
                #1;
                chk("idle_htrans", 64'(htrans), 64'd0);
            end
        end
    end

    // Scoreboard monitor: every response pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge hclk);
            if (hresetn && rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp: got rsp_valid err=%0d expected none (cycle %0d)", rsp_err, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    initial begin
        plan_t p;
        int waitc;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
        repeat (2) @(negedge hclk);
        #1;
        chk_reset_outputs("reset");
        #2 hresetn = 1'b1;
        @(negedge hclk);
        chk("first_cycle_cmd_ready", 64'(cmd_ready), 64'd1);

        issue(mk(1, 32'h100, 3'd2, 32'hA5A5_0001, 0, 0, 0, 32'h0), 1);
        issue(mk(0, 32'h200, 3'd2, 32'h0, 5, 2, 0, 32'hDEAD_BEEF), 1);
        issue(mk(0, 32'h304, 3'd2, 32'h0, 0, 1, 1, 32'h1234_5678), 1);
        issue(mk(1, 32'h400, 3'd1, 32'h0000_BEEF, TMO + 2, 0, 0, 32'h0), 1);
        issue(mk(0, 32'h501, 3'd0, 32'h0, TMO - 1, 0, 0, 32'h0000_0055), 1);
        issue(mk(1, 32'h102, 3'd2, 32'hFFFF_0000, 0, 0, 0, 32'h0), 1);
        issue(mk(0, 32'h108, 3'd3, 32'h0, 0, 0, 0, 32'h0), 1);
        issue(mk(1, 32'h700, 3'd2, 32'hCAFE_F00D, 2, 3, 1, 32'h0), 1);
        drain();

        for (int i = 0; i < 60; i++) begin
            p.write = 1'($urandom);
            p.size  = 3'($urandom_range(0, 3));
            p.addr  = $urandom;
            if ($urandom_range(0, 3) != 0) p.addr = p.addr & ~((32'd1 << p.size) - 32'd1);
            p.wdata = $urandom;
            p.rdata = $urandom;
            p.g     = ($urandom_range(0, 7) == 0) ? TMO + int'($urandom_range(0, 2))
                                                  : int'($urandom_range(0, 3));
            p.w     = int'($urandom_range(0, 3));
            p.err   = ($urandom_range(0, 4) == 0);
            if (p.err && p.w == 0) p.w = 1;
            issue(p, 1);
            repeat ($urandom_range(0, 2)) @(negedge hclk);
        end
        drain();

        // Reset in the middle of a data phase: no response may ever appear for it.
        issue(mk(1, 32'h600, 3'd2, 32'h0BAD_0BAD, 0, 3, 0, 32'h0), 0);
        waitc = 0;
        while (phase != 2 && waitc < 50) begin
            @(negedge hclk);
            waitc++;
        end
        chk("reach_data_phase", 64'(phase), 64'd2);
        @(negedge hclk);
        #3 hresetn = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(negedge hclk);
        #3 hresetn = 1'b1;
        @(negedge hclk);
        chk("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);
        repeat (6) @(negedge hclk);

        issue(mk(0, 32'h804, 3'd2, 32'h0, 1, 1, 0, 32'h7777_1111), 1);
        drain();
        repeat (3) @(negedge hclk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
